// File: rtl/light_override_port_pkg.sv
// ---------------------------------------------------------------------------
// light_override_port_pkg
// Shared light-path definitions: default brightness width, debug frame
// length, bit-counter width, the debug FSM state encoding and a saturating
// increment helper used by the frame bit counter.
// ---------------------------------------------------------------------------
package light_override_port_pkg;

  localparam int LIGHT_W_DEF = 15;
  localparam int FRAME_LEN   = 16;
  localparam int CNT_W       = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Counter sticks at all-ones so oversized frames can never wrap back to 16.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/light_override_port_if.sv
// ---------------------------------------------------------------------------
// light_override_port_if
// Debug serial bus between a host (master) and the override port (slave).
//   dbg_sclk : serial clock, driven by the host
//   dbg_csn  : active-low frame select, driven by the host
//   dbg_sdi  : host-to-port data, MSB first
//   dbg_sdo  : port-to-host readback data, MSB first
// ---------------------------------------------------------------------------
interface light_override_port_if;
  import light_override_port_pkg::*;

  logic dbg_sclk;
  logic dbg_csn;
  logic dbg_sdi;
  logic dbg_sdo;

  modport master (output dbg_sclk, output dbg_csn, output dbg_sdi, input dbg_sdo);
  modport slave  (input dbg_sclk, input dbg_csn, input dbg_sdi, output dbg_sdo);

endinterface

// File: rtl/dbg_sync_edge.sv
// ---------------------------------------------------------------------------
// dbg_sync_edge
// Multi-flop synchronizer for one asynchronous debug line plus rising and
// falling edge detection on the synchronized level.
//   clk_i    : system clock
//   rst_ni   : synchronous active-low reset
//   async_i  : asynchronous input line
//   rise_o   : one-cycle pulse on a synchronized 0->1 transition
//   fall_o   : one-cycle pulse on a synchronized 1->0 transition
// Edges are suppressed until the chain has been refilled with real samples
// after reset, so a line that is already away from its idle level when reset
// releases is not mistaken for a fresh transition.
// ---------------------------------------------------------------------------
module dbg_sync_edge
  import light_override_port_pkg::*;
#(
  parameter int   STAGES   = 2,
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic [STAGES:0]   vld_q;
  logic              level;
  logic              valid;

  // Synchronizer chain, previous-level register and post-reset settle tracker.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{IDLE_VAL}};
      prev_q <= IDLE_VAL;
      vld_q  <= '0;
    end else begin
      sync_q <= (sync_q << 1) | STAGES'(async_i);
      prev_q <= level;
      vld_q  <= {vld_q[STAGES-1:0], 1'b1};
    end
  end

  assign level  = sync_q[STAGES-1];
  assign valid  = vld_q[STAGES];
  assign rise_o = valid & level & ~prev_q;
  assign fall_o = valid & ~level & prev_q;

endmodule

// File: rtl/light_override_port.sv
// ---------------------------------------------------------------------------
// light_override_port
// Debug override port sitting between the gray generator and the PWM driver.
// A host shifts a 16-bit frame in over an asynchronous serial link
// ({enable, value[14:0]}); a complete frame becomes pending and is applied at
// the next frame_start pulse. During every frame the current
// {override_active, light_temp} word is shifted back out on sdo.
//   I_clk, I_rst_n        : system clock, synchronous active-low reset
//   I_dbg_sclk/csn/sdi    : asynchronous debug serial inputs
//   O_dbg_sdo             : serial readback, MSB first
//   I_light_temp          : brightness word from the gray generator
//   I_frame_start         : override apply point
//   O_light_temp          : registered brightness word to the PWM driver
//   O_override_active     : override currently applied
//   O_cmd_err             : one-cycle pulse on a frame of the wrong length
// ---------------------------------------------------------------------------
module light_override_port
  import light_override_port_pkg::*;
#(
  parameter int LIGHT_W     = LIGHT_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic               I_clk,
  input  logic               I_rst_n,
  input  logic               I_dbg_sclk,
  input  logic               I_dbg_csn,
  input  logic               I_dbg_sdi,
  output logic               O_dbg_sdo,
  input  logic [LIGHT_W-1:0] I_light_temp,
  input  logic               I_frame_start,
  output logic [LIGHT_W-1:0] O_light_temp,
  output logic               O_override_active,
  output logic               O_cmd_err
);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [FRAME_LEN-1:0]   shift_q, shift_d;
  logic [FRAME_LEN-1:0]   shadow_q, shadow_d;
  logic                   pending_q, pending_d;
  logic                   pend_en_q, pend_en_d;
  logic [LIGHT_W-1:0]     pend_val_q, pend_val_d;
  logic                   ovr_en_q, ovr_en_d;
  logic [LIGHT_W-1:0]     ovr_val_q, ovr_val_d;
  logic [LIGHT_W-1:0]     light_q, light_d;
  logic                   err_q, err_d;
  logic [SYNC_STAGES-1:0] sdi_sync_q;
  logic                   sdi_s;
  logic                   sclk_rise, sclk_fall;
  logic                   csn_rise, csn_fall;
  logic                   commit;

  dbg_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sclk_sync (
    .clk_i   (I_clk),
    .rst_ni  (I_rst_n),
    .async_i (I_dbg_sclk),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  dbg_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_csn_sync (
    .clk_i   (I_clk),
    .rst_ni  (I_rst_n),
    .async_i (I_dbg_csn),
    .rise_o  (csn_rise),
    .fall_o  (csn_fall)
  );

  // sdi needs only a level; same depth as sclk keeps data aligned to its edge.
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      sdi_sync_q <= '0;
    end else begin
      sdi_sync_q <= (sdi_sync_q << 1) | SYNC_STAGES'(I_dbg_sdi);
    end
  end

  assign sdi_s = sdi_sync_q[SYNC_STAGES-1];

  // Frame FSM, pending buffer and override/apply logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    shadow_d   = shadow_q;
    pending_d  = pending_q;
    pend_en_d  = pend_en_q;
    pend_val_d = pend_val_q;
    ovr_en_d   = ovr_en_q;
    ovr_val_d  = ovr_val_q;
    err_d      = 1'b0;
    commit     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (csn_fall) begin
          state_d  = ST_SHIFT;
          cnt_d    = '0;
          shift_d  = '0;
          shadow_d = FRAME_LEN'({ovr_en_q, I_light_temp});
        end
      end
      ST_SHIFT: begin
        if (sclk_rise) begin
          shift_d = {shift_q[FRAME_LEN-2:0], sdi_s};
          cnt_d   = sat_inc(cnt_q);
        end
        if (sclk_fall) begin
          shadow_d = shadow_q << 1;
        end
        if (csn_rise) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (cnt_q == CNT_W'(FRAME_LEN)) begin
          commit = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Apply uses the old pending contents, so a same-cycle commit waits a frame.
    if (I_frame_start && pending_q) begin
      ovr_en_d  = pend_en_q;
      ovr_val_d = pend_val_q;
      pending_d = 1'b0;
    end
    if (commit) begin
      pending_d  = 1'b1;
      pend_en_d  = shift_q[FRAME_LEN-1];
      pend_val_d = shift_q[LIGHT_W-1:0];
    end

    light_d = ovr_en_d ? ovr_val_d : I_light_temp;
  end

  // State registers.
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      shadow_q   <= '0;
      pending_q  <= 1'b0;
      pend_en_q  <= 1'b0;
      pend_val_q <= '0;
      ovr_en_q   <= 1'b0;
      ovr_val_q  <= '0;
      light_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      shadow_q   <= shadow_d;
      pending_q  <= pending_d;
      pend_en_q  <= pend_en_d;
      pend_val_q <= pend_val_d;
      ovr_en_q   <= ovr_en_d;
      ovr_val_q  <= ovr_val_d;
      light_q    <= light_d;
      err_q      <= err_d;
    end
  end

  assign O_dbg_sdo         = (state_q == ST_SHIFT) & shadow_q[FRAME_LEN-1];
  assign O_light_temp      = light_q;
  assign O_override_active = ovr_en_q;
  assign O_cmd_err         = err_q;

endmodule

// File: tb/tb_light_override_port.sv
// ---------------------------------------------------------------------------
// tb_light_override_port
// Directed bench for light_override_port. Stimulus tasks push expected output
// words, readback streams and error pulses into scoreboard queues; a single
// monitor process samples the DUT just after each falling clock edge and
// pops/compares whenever an expectation or a DUT event is due.
// ---------------------------------------------------------------------------
module tb_light_override_port;
  import light_override_port_pkg::*;

  localparam int LW = LIGHT_W_DEF;

  typedef struct packed {
    logic [LW-1:0] light;
    logic          act;
  } outExp_t;

  typedef struct packed {
    logic [31:0] bits;
    logic        chk;
  } sdoExp_t;

  logic          clk        = 1'b0;
  logic          rstN       = 1'b0;
  logic [LW-1:0] lightTemp  = '0;
  logic          frameStart = 1'b0;
  logic [LW-1:0] outLight;
  logic          outAct;
  logic          cmdErr;

  light_override_port_if dbg();

  int      vectorsApplied = 0;
  int      miscompares    = 0;
  int      errExpected    = 0;
  int      errSeen        = 0;
  outExp_t outQ[$];
  string   nameQ[$];
  sdoExp_t sdoQ[$];
  logic    endReq  = 1'b0;
  logic    monDone = 1'b0;

  always #5 clk = ~clk;

  light_override_port #(.LIGHT_W(LW), .SYNC_STAGES(2)) dut (
    .I_clk             (clk),
    .I_rst_n           (rstN),
    .I_dbg_sclk        (dbg.dbg_sclk),
    .I_dbg_csn         (dbg.dbg_csn),
    .I_dbg_sdi         (dbg.dbg_sdi),
    .O_dbg_sdo         (dbg.dbg_sdo),
    .I_light_temp      (lightTemp),
    .I_frame_start     (frameStart),
    .O_light_temp      (outLight),
    .O_override_active (outAct),
    .O_cmd_err         (cmdErr)
  );

  // Monitor: one process owns every comparison and both counters.
  outExp_t     e;
  string       nm;
  sdoExp_t     s;
  logic [31:0] cap      = '0;
  int          capBits  = 0;
  logic        sclkPrev = 1'b0;
  logic        csnPrev  = 1'b1;

  always begin
    @(negedge clk);
    #1;
    while (outQ.size() > 0) begin
      e  = outQ.pop_front();
      nm = nameQ.pop_front();
      vectorsApplied++;
      if (outLight !== e.light || outAct !== e.act || dbg.dbg_sdo !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL %s: got light=%h act=%b sdo=%b, want light=%h act=%b sdo=0",
                 nm, outLight, outAct, dbg.dbg_sdo, e.light, e.act);
      end
    end
    if (cmdErr === 1'b1) begin
      errSeen++;
      vectorsApplied++;
      if (errSeen > errExpected) begin
        miscompares++;
        $display("[TB] FAIL cmd_err pulse: got pulse #%0d, want at most %0d", errSeen, errExpected);
      end
    end
    if (dbg.dbg_csn === 1'b0 && csnPrev === 1'b1) begin
      cap     = '0;
      capBits = 0;
    end else if (dbg.dbg_csn === 1'b0 && dbg.dbg_sclk === 1'b1 && sclkPrev === 1'b0) begin
      cap = {cap[30:0], dbg.dbg_sdo};
      capBits++;
    end
    if (dbg.dbg_csn === 1'b1 && csnPrev === 1'b0 && sdoQ.size() > 0) begin
      s = sdoQ.pop_front();
      if (s.chk) begin
        vectorsApplied++;
        if (cap !== s.bits) begin
          miscompares++;
          $display("[TB] FAIL sdo readback (%0d bits): got %h, want %h", capBits, cap, s.bits);
        end
      end
    end
    sclkPrev = dbg.dbg_sclk;
    csnPrev  = dbg.dbg_csn;
    if (endReq && !monDone) begin
      vectorsApplied++;
      if (errSeen != errExpected) begin
        miscompares++;
        $display("[TB] FAIL cmd_err count: got %0d, want %0d", errSeen, errExpected);
      end
      monDone = 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [LW-1:0] light, input logic act);
    outExp_t x;
    x.light = light;
    x.act   = act;
    outQ.push_back(x);
    nameQ.push_back(name);
  endtask

  task automatic setLight(input logic [LW-1:0] v);
    @(negedge clk);
    lightTemp = v;
    @(negedge clk);
  endtask

  task automatic pulseFrameStart();
    @(negedge clk);
    frameStart = 1'b1;
    @(negedge clk);
    frameStart = 1'b0;
  endtask

  task automatic sendBit(input logic b);
    dbg.dbg_sdi = b;
    repeat (5) @(negedge clk);
    dbg.dbg_sclk = 1'b1;
    repeat (5) @(negedge clk);
    dbg.dbg_sclk = 1'b0;
  endtask

  // Sends an nBits frame (MSB first); rb is the readback word expected on sdo.
  // fsAt > 0 pulses frame_start that many cycles after csn rises.
  task automatic applyStimulus(input logic [31:0] data, input int nBits,
                               input logic [15:0] rb, input logic expErr, input int fsAt);
    sdoExp_t     x;
    logic [31:0] ex;
    ex = '0;
    for (int i = 0; i < nBits; i++) begin
      ex = {ex[30:0], (i < 16) ? rb[15-i] : 1'b0};
    end
    x.bits = ex;
    x.chk  = 1'b1;
    sdoQ.push_back(x);
    if (expErr) errExpected++;
    @(negedge clk);
    dbg.dbg_csn = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < nBits; i++) begin
      sendBit(data[nBits-1-i]);
    end
    repeat (5) @(negedge clk);
    dbg.dbg_csn = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      frameStart = (c == fsAt);
    end
    frameStart = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: bench did not complete in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    dbg.dbg_sclk = 1'b0;
    dbg.dbg_csn  = 1'b1;
    dbg.dbg_sdi  = 1'b0;
    lightTemp    = 15'h1234;

    repeat (4) @(negedge clk);
    checkOutput("reset state", 15'h0000, 1'b0);
    rstN = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("passthrough 1234", 15'h1234, 1'b0);

    // Readback of {0, 1ABC} while writing override 0x8123.
    setLight(15'h1ABC);
    applyStimulus(32'h8123, 16, 16'h1ABC, 1'b0, 0);
    checkOutput("pending not applied", 15'h1ABC, 1'b0);
    setLight(15'h0456);
    checkOutput("tracks input before apply", 15'h0456, 1'b0);
    pulseFrameStart();
    checkOutput("apply 8123", 15'h0123, 1'b1);
    pulseFrameStart();
    checkOutput("apply with nothing pending", 15'h0123, 1'b1);
    setLight(15'h2222);
    checkOutput("override ignores input", 15'h0123, 1'b1);

    // Short, long and empty frames; readback shows active bit set.
    applyStimulus(32'h00007FFF, 15, 16'hA222, 1'b1, 0);
    applyStimulus(32'h0001FFFF, 17, 16'hA222, 1'b1, 0);
    applyStimulus(32'h00000000, 0, 16'hA222, 1'b1, 0);
    pulseFrameStart();
    checkOutput("bad frames discarded", 15'h0123, 1'b1);

    // Commit of 0x8055 coincides with frame_start while 0x8011 is pending.
    applyStimulus(32'h8011, 16, 16'hA222, 1'b0, 0);
    applyStimulus(32'h8055, 16, 16'hA222, 1'b0, 3);
    checkOutput("same-cycle applies older", 15'h0011, 1'b1);
    pulseFrameStart();
    checkOutput("newer applied next", 15'h0055, 1'b1);

    // Disable frame returns to passthrough.
    applyStimulus(32'h0000, 16, 16'hA222, 1'b0, 0);
    checkOutput("disable pending", 15'h0055, 1'b1);
    pulseFrameStart();
    checkOutput("override disabled", 15'h2222, 1'b0);

    // Reset in the middle of a frame, csn held low across reset release.
    setLight(15'h3333);
    checkOutput("passthrough 3333", 15'h3333, 1'b0);
    sdoQ.push_back(sdoExp_t'(0));
    @(negedge clk);
    dbg.dbg_csn = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) sendBit(1'b1);
    @(negedge clk);
    rstN = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset mid-frame", 15'h0000, 1'b0);
    rstN = 1'b1;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 16; i++) sendBit(1'b1);
    repeat (5) @(negedge clk);
    dbg.dbg_csn = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("no frame after reset", 15'h3333, 1'b0);
    pulseFrameStart();
    checkOutput("no pending after reset", 15'h3333, 1'b0);

    endReq = 1'b1;
    wait (monDone === 1'b1);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
